// File: rtl/scan_loader.sv
// scan_loader: accepts bytes on a valid/ready port and shifts them MSB first
// into one of eight pattern-buffer scan chains, while capturing the bits that
// fall out of the chain and returning them as read-back bytes.
module scan_loader #(
  parameter int buffer_size  = 22,
  parameter int buffer_width = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [2:0]              addr,
  input  logic [buffer_width-1:0] din,
  input  logic                    din_valid,
  output logic                    din_ready,
  output logic                    sin,
  output logic                    ssel,
  output logic [2:0]              saddr,
  input  logic                    sout,
  output logic [buffer_width-1:0] dout,
  output logic                    dout_valid,
  output logic                    busy,
  output logic                    done
);

  localparam int BYTE_W = (buffer_size  > 1) ? $clog2(buffer_size)  : 1;
  localparam int BIT_W  = (buffer_width > 1) ? $clog2(buffer_width) : 1;
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(buffer_size - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(buffer_width - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [2:0]              saddr_q, saddr_d;
  logic [BYTE_W-1:0]       byte_cnt_q, byte_cnt_d;
  logic [BIT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [buffer_width-1:0] shreg_q, shreg_d;
  logic [buffer_width-1:0] cap_q, cap_d;
  logic [buffer_width-1:0] dout_q, dout_d;
  logic                    dout_valid_q, dout_valid_d;
  logic                    busy_q, busy_d;

  // Next-state and datapath updates; every register holds unless its state acts.
  always_comb begin
    state_d      = state_q;
    saddr_d      = saddr_q;
    byte_cnt_d   = byte_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    cap_d        = cap_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    busy_d       = busy_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          saddr_d    = addr;
          busy_d     = 1'b1;
          byte_cnt_d = '0;
          state_d    = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (din_valid) begin
          shreg_d   = din;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end else begin
          state_d = WAIT;
        end
      end
      SHIFT: begin
        shreg_d = {shreg_q[buffer_width-2:0], 1'b0};
        cap_d   = {cap_q[buffer_width-2:0], sout};
        if (bit_cnt_q == LAST_BIT) begin
          // The first bit returned by the chain ends up in the MSB.
          dout_d       = {cap_q[buffer_width-2:0], sout};
          dout_valid_d = 1'b1;
          if (byte_cnt_q == LAST_BYTE) begin
            state_d = DONE;
          end else begin
            byte_cnt_d = byte_cnt_q + BYTE_W'(1);
            state_d    = WAIT;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous reset taking priority over all inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      saddr_q      <= 3'd0;
      byte_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      cap_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      saddr_q      <= saddr_d;
      byte_cnt_q   <= byte_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      cap_q        <= cap_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign din_ready  = (state_q == WAIT);
  assign ssel       = (state_q == SHIFT);
  assign sin        = (state_q == SHIFT) ? shreg_q[buffer_width-1] : 1'b0;
  assign done       = (state_q == DONE);
  assign saddr      = saddr_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_scan_loader.sv
// Directed bench for scan_loader: default-size instance attached to a 176-bit
// chain model, plus a 4-byte instance for the small-buffer timing.
module tb_scan_loader;

  logic       clk = 1'b0;
  logic       reset, start, din_valid, sout, preload;
  logic [2:0] addr, saddr;
  logic [7:0] din, dout;
  logic       din_ready, sin, ssel, dout_valid, busy, done;
  logic [175:0] chain;

  logic       start4, din_valid4, sout4;
  logic [2:0] addr4, saddr4;
  logic [7:0] din4, dout4;
  logic       din_ready4, sin4, ssel4, dout_valid4, busy4, done4;

  int err_cnt = 0;
  int chk_cnt = 0;

  int r_cyc, r_ssel, r_sin_err, r_dv, r_dout_err, r_saddr_err, r_busy_err;
  int r_ready_err, r_done_dv, r_busy_after, r_done_after;

  always #5 clk = ~clk;

  scan_loader u_dut (
    .clk(clk), .reset(reset), .start(start), .addr(addr), .din(din),
    .din_valid(din_valid), .din_ready(din_ready), .sin(sin), .ssel(ssel),
    .saddr(saddr), .sout(sout), .dout(dout), .dout_valid(dout_valid),
    .busy(busy), .done(done)
  );

  scan_loader #(.buffer_size(4), .buffer_width(8)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4), .addr(addr4), .din(din4),
    .din_valid(din_valid4), .din_ready(din_ready4), .sin(sin4), .ssel(ssel4),
    .saddr(saddr4), .sout(sout4), .dout(dout4), .dout_valid(dout_valid4),
    .busy(busy4), .done(done4)
  );

  // Scan chain model: shifts sin in while ssel is high, returns its oldest bit.
  always @(posedge clk) begin
    if (preload) chain <= {22{8'hA5}};
    else if (ssel) chain <= {chain[174:0], sin};
  end
  assign sout  = chain[175];
  assign sout4 = 1'b0;

  task automatic chk(input string tag, input int obs, input int exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete load; gap = idle WAIT cycles before every byte after the first,
  // cmode selects constant cval bytes instead of the byte index, poke = cycle at
  // which a stray start with addr=2 is pulsed (0 = none).
  task automatic do_load(input logic [2:0] a, input int gap, input bit cmode,
                         input logic [7:0] cval, input bit chk_dout,
                         input logic [7:0] exp_dout, input int poke);
    int sh, bi, gl;
    bit acc;
    logic [7:0] bv;
    r_cyc = 0; r_ssel = 0; r_sin_err = 0; r_dv = 0; r_dout_err = 0;
    r_saddr_err = 0; r_busy_err = 0; r_ready_err = 0;
    sh = 0; bi = 0; gl = 0;
    din = cmode ? cval : 8'(bi);
    din_valid = 1'b0;
    addr = a; start = 1'b1;
    tick();
    start = 1'b0; r_cyc = 1;
    while (done !== 1'b1 && r_cyc < 1000) begin
      if (ssel === 1'b1) begin
        bv = cmode ? cval : 8'(sh / 8);
        if (sin !== bv[3'(7 - (sh % 8))]) r_sin_err++;
        sh++;
      end else if (sin !== 1'b0) r_sin_err++;
      if (dout_valid === 1'b1) begin
        r_dv++;
        if (chk_dout && dout !== exp_dout) r_dout_err++;
      end
      if (saddr !== a) r_saddr_err++;
      if (busy !== 1'b1) r_busy_err++;
      if (din_ready === 1'b1 && ssel === 1'b1) r_ready_err++;
      acc = 1'b0;
      if (poke != 0 && r_cyc == poke) begin start = 1'b1; addr = 3'd2; end
      else start = 1'b0;
      if (din_ready === 1'b1 && gl == 0) begin din_valid = 1'b1; acc = 1'b1; end
      else if (din_ready === 1'b1) begin din_valid = 1'b0; gl--; end
      else din_valid = (gap == 0);
      tick();
      r_cyc++;
      if (acc) begin bi++; gl = gap; din = cmode ? cval : 8'(bi); end
    end
    r_ssel = sh;
    r_done_dv = 32'(dout_valid);
    if (dout_valid === 1'b1) begin
      r_dv++;
      if (chk_dout && dout !== exp_dout) r_dout_err++;
    end
    start = 1'b0; din_valid = 1'b0;
    tick();
    r_busy_after = 32'(busy);
    r_done_after = 32'(done);
  endtask

  initial begin
    int n, sh, c, dv;
    reset = 1'b1; start = 1'b0; addr = 3'd0; din = 8'd0; din_valid = 1'b0;
    preload = 1'b1;
    start4 = 1'b0; addr4 = 3'd0; din4 = 8'h11; din_valid4 = 1'b1;
    tick(); tick();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ssel", 32'(ssel), 0);
    chk("rst_ready", 32'(din_ready), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_dv", 32'(dout_valid), 0);
    chk("rst_saddr", 32'(saddr), 0);
    chk("rst_dout", 32'(dout), 0);
    chk("rst_sin", 32'(sin), 0);
    reset = 1'b0; preload = 1'b0;
    tick();

    // Incrementing bytes 0x00..0x15 into buffer 5, din_valid held.
    do_load(3'd5, 0, 1'b0, 8'h00, 1'b0, 8'h00, 0);
    chk("t1_done_cyc", r_cyc, 199);
    chk("t1_ssel_cnt", r_ssel, 176);
    chk("t1_sin_err", r_sin_err, 0);
    chk("t1_saddr_err", r_saddr_err, 0);
    chk("t1_busy_err", r_busy_err, 0);
    chk("t1_dv_cnt", r_dv, 22);
    chk("t1_done_dv", r_done_dv, 1);
    chk("t1_ready_ssel", r_ready_err, 0);
    chk("t1_busy_after", r_busy_after, 0);
    chk("t1_done_after", r_done_after, 0);

    // Chain full of 0xA5, load 0x3C twice: first read-back A5, then 3C.
    preload = 1'b1; tick(); preload = 1'b0;
    do_load(3'd0, 0, 1'b1, 8'h3C, 1'b1, 8'hA5, 0);
    chk("t2a_dv_cnt", r_dv, 22);
    chk("t2a_dout_err", r_dout_err, 0);
    do_load(3'd0, 0, 1'b1, 8'h3C, 1'b1, 8'h3C, 0);
    chk("t2b_dv_cnt", r_dv, 22);
    chk("t2b_dout_err", r_dout_err, 0);

    // Five idle WAIT cycles before each byte after the first.
    do_load(3'd3, 5, 1'b0, 8'h00, 1'b0, 8'h00, 0);
    chk("t3_done_cyc", r_cyc, 304);
    chk("t3_ssel_cnt", r_ssel, 176);
    chk("t3_sin_err", r_sin_err, 0);
    chk("t3_dv_cnt", r_dv, 22);
    chk("t3_ready_ssel", r_ready_err, 0);

    // Stray start with addr=2 while busy on buffer 7.
    do_load(3'd7, 0, 1'b0, 8'h00, 1'b0, 8'h00, 20);
    chk("t4_saddr_err", r_saddr_err, 0);
    chk("t4_done_cyc", r_cyc, 199);
    repeat (5) tick();
    chk("t4_no_reload_busy", 32'(busy), 0);
    chk("t4_no_reload_ready", 32'(din_ready), 0);
    chk("t4_saddr_hold", 32'(saddr), 7);

    // Reset at bit 3 of byte 10.
    addr = 3'd1; start = 1'b1; tick(); start = 1'b0;
    din = 8'h55; din_valid = 1'b1; n = 0; sh = 0;
    while (n < 300 && !(ssel === 1'b1 && sh == 83)) begin
      if (ssel === 1'b1) sh++;
      tick(); n++;
    end
    chk("t5_reached_shift", 32'(ssel), 1);
    reset = 1'b1; start = 1'b1;
    tick();
    chk("t5_ssel", 32'(ssel), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_dv", 32'(dout_valid), 0);
    chk("t5_ready", 32'(din_ready), 0);
    chk("t5_saddr", 32'(saddr), 0);
    reset = 1'b0; start = 1'b0; din_valid = 1'b0;
    tick();
    chk("t5_dv_after", 32'(dout_valid), 0);
    do_load(3'd4, 0, 1'b0, 8'h00, 1'b0, 8'h00, 0);
    chk("t5_fresh_done_cyc", r_cyc, 199);
    chk("t5_fresh_dv_cnt", r_dv, 22);
    chk("t5_fresh_saddr_err", r_saddr_err, 0);

    // Four-byte instance: 4*(8+1) cycles from WAIT entry to DONE.
    addr4 = 3'd6; start4 = 1'b1; tick(); start4 = 1'b0;
    c = 1; dv = 0;
    while (done4 !== 1'b1 && c < 200) begin
      if (dout_valid4 === 1'b1) dv++;
      tick(); c++;
    end
    if (dout_valid4 === 1'b1) dv++;
    chk("t6_done_cyc", c, 37);
    chk("t6_dv_cnt", dv, 4);
    chk("t6_saddr", 32'(saddr4), 6);
    tick();
    chk("t6_busy_after", 32'(busy4), 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
